apb_mem_slave: RTL and testbench

Parametrised APB slave with an internal RAM: the next generation of the fixed 256 x 16 `apbslave`. Width, depth and per-direction wait states are set by parameters. Out-of-range accesses return PSLVERR, and byte-lane write strobes are optional. It sits on the peripheral bus behind the APB bridge as a scratch/config memory and is driven by the same directed write/read bench flow.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_ram.sv | 56 +++++
 rtl/apb_mem_slave.sv | 111 +++++++++++
 tb/tb_apb_mem_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB scratch/config memory slave: FSM encoding,
// wait-counter width and strobe-lane helper.
package apb_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t IDLE   = 2'd0;
  localparam apb_state_t SETUP  = 2'd1;
  localparam apb_state_t ACCESS = 2'd2;

  localparam int WCNT_W = 4;

  function automatic int strb_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_ram.sv
// DEPTH x DATA_W storage with one synchronous read port (with synchronous
// clear) and one synchronous write port qualified by per-byte enables.
module apb_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int LANES  = 2
) (
  input  logic              pclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  wbe,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bmask;

  // Bits beyond the last full byte belong to the top lane.
  function automatic int lane_of(input int b);
    return ((b / 8) >= LANES) ? (LANES - 1) : (b / 8);
  endfunction

  always_comb begin
    bmask = '0;
    for (int b = 0; b < DATA_W; b++) begin
      bmask[b] = wbe[lane_of(b)];
    end
  end

  always_ff @(posedge pclk) begin
    if (we) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (bmask[b]) begin
          mem[waddr[IW-1:0]][b] <= wdata[b];
        end
      end
    end
  end

  // Clear has priority so out-of-range reads never index the array.
  always_ff @(posedge pclk) begin
    if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB slave fronting an internal RAM with configurable wait
// states and PSLVERR on out-of-range addresses. Define APB_PSTRB_EN for pstrb.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int WAIT_WR = 0,
  parameter int WAIT_RD = 0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              pwrite,
`ifdef APB_PSTRB_EN
  input  logic [strb_lanes(DATA_W)-1:0] pstrb,
`endif
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int LANES = (strb_lanes(DATA_W) < 1) ? 1 : strb_lanes(DATA_W);

  localparam logic [WCNT_W-1:0] WR_LOAD = WCNT_W'(WAIT_WR);
  localparam logic [WCNT_W-1:0] RD_LOAD = WCNT_W'(WAIT_RD);

  apb_state_t        state;
  logic [WCNT_W-1:0] wcnt;
  logic              err;

  logic              addr_err;
  logic              ram_we;
  logic              ram_re;
  logic              ram_rclr;
  logic [LANES-1:0]  ram_wbe;

  assign addr_err = ({1'b0, paddr} >= (ADDR_W + 1)'(DEPTH));

  assign pready  = (state == ACCESS) && (wcnt == '0);
  assign pslverr = pready && err;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          state <= ACCESS;
          wcnt  <= pwrite ? WR_LOAD : RD_LOAD;
          err   <= addr_err;
        end
        ACCESS: begin
          // A master that drops psel mid-transfer gets the transfer abandoned.
          if (!psel) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else begin
            state <= (psel && !penable) ? SETUP : IDLE;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // Commit on the completion edge only; reset on that edge drops the write.
  assign ram_we   = pready && psel && pwrite && !err && !rst;
  assign ram_re   = (state == SETUP) && !pwrite;
  assign ram_rclr = rst || (ram_re && addr_err);

`ifdef APB_PSTRB_EN
  assign ram_wbe = pstrb;
`else
  assign ram_wbe = '1;
`endif

  apb_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LANES  (LANES)
  ) u_ram (
    .pclk  (pclk),
    .we    (ram_we),
    .waddr (paddr),
    .wdata (pwdata),
    .wbe   (ram_wbe),
    .re    (ram_re),
    .rclr  (ram_rclr),
    .raddr (paddr),
    .rdata (prdata)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (defaults, wait states,
// reduced depth) share the bus; psel selects which one is addressed.
module tb_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [15:0] pwdata;
  logic [1:0]  pstrb;

  logic [2:0]  rdy;
  logic [2:0]  serr;
  logic [15:0] rd0, rd1, rd2;

  int ncmp  = 0;
  int nfail = 0;

  always #5 pclk = ~pclk;

  apb_mem_slave u_def (
    .pclk(pclk), .rst(rst), .psel(sel[0]), .penable(penable), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(rdy[0]), .prdata(rd0), .pslverr(serr[0])
  );

  apb_mem_slave #(.WAIT_WR(2), .WAIT_RD(3)) u_wait (
    .pclk(pclk), .rst(rst), .psel(sel[1]), .penable(penable), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(rdy[1]), .prdata(rd1), .pslverr(serr[1])
  );

  apb_mem_slave #(.DEPTH(200)) u_d200 (
    .pclk(pclk), .rst(rst), .psel(sel[2]), .penable(penable), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(rdy[2]), .prdata(rd2), .pslverr(serr[2])
  );

  function automatic logic [15:0] prd(input int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge; consecutive calls are
  // back-to-back with no idle cycle. cyc = edges from setup until pready.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [15:0] wd, input logic [1:0] st,
                      output logic [15:0] rd, output logic er, output int cyc);
    bit done;
    sel = 3'(1 << d); penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1'b1; cyc = 0; done = 1'b0; rd = '0; er = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (rdy[d]) begin
        done = 1'b1; rd = prd(d); er = serr[d];
      end else begin
        @(posedge pclk); #1;
        cyc++;
      end
    end
    chk("xfer_done", {31'b0, done}, 32'd1);
    @(posedge pclk); #1;
    sel = '0; penable = 1'b0;
  endtask

  logic [15:0] rdv;
  logic        erv;
  int          cyc;

  initial begin
    rst = 1'b1; sel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = 2'b11;
    repeat (3) @(posedge pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready",  {31'b0, rdy[d]},  32'd0);
      chk("rst_pslverr", {31'b0, serr[d]}, 32'd0);
      chk("rst_prdata",  {16'b0, prd(d)},  32'd0);
    end
    rst = 1'b0;
    @(posedge pclk); #1;

    // Defaults: fill and read back every word, zero wait states.
    for (int i = 0; i < 256; i++) begin
      xfer(0, 1'b1, 8'(i), 16'(i), 2'b11, rdv, erv, cyc);
      chk("def_wr_err", {31'b0, erv}, 32'd0);
      chk("def_wr_lat", 32'(cyc), 32'd1);
    end
    for (int i = 0; i < 256; i++) begin
      xfer(0, 1'b0, 8'(i), 16'h0, 2'b11, rdv, erv, cyc);
      chk("def_rd_data", {16'b0, rdv}, 32'(i));
      chk("def_rd_err",  {31'b0, erv}, 32'd0);
      chk("def_rd_lat",  32'(cyc), 32'd1);
    end

    // Back-to-back write then read of the same address.
    xfer(0, 1'b1, 8'h40, 16'hCAFE, 2'b11, rdv, erv, cyc);
    xfer(0, 1'b0, 8'h40, 16'h0,    2'b11, rdv, erv, cyc);
    chk("b2b_def_data", {16'b0, rdv}, 32'hCAFE);

    // Wait states: write 2, read 3.
    xfer(1, 1'b1, 8'h0B, 16'hAA55, 2'b11, rdv, erv, cyc);
    chk("wait_wr_lat", 32'(cyc), 32'd3);
    chk("wait_wr_err", {31'b0, erv}, 32'd0);
    xfer(1, 1'b0, 8'h0B, 16'h0, 2'b11, rdv, erv, cyc);
    chk("wait_rd_lat",  32'(cyc), 32'd4);
    chk("wait_rd_data", {16'b0, rdv}, 32'hAA55);

    // psel dropped during the access phase: write discarded.
    sel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0B; pwdata = 16'h7777;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; sel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_pready", {31'b0, rdy[1]}, 32'd0);
    repeat (3) @(posedge pclk);
    #1;
    xfer(1, 1'b0, 8'h0B, 16'h0, 2'b11, rdv, erv, cyc);
    chk("abort_data", {16'b0, rdv}, 32'hAA55);

    // Reset pulsed in the access phase of a waited write.
    xfer(1, 1'b1, 8'h03, 16'h1111, 2'b11, rdv, erv, cyc);
    sel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 16'hBEEF;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; rst = 1'b1;
    @(posedge pclk); #1;
    chk("rstmid_pready",  {31'b0, rdy[1]},  32'd0);
    chk("rstmid_pslverr", {31'b0, serr[1]}, 32'd0);
    chk("rstmid_prdata",  {16'b0, rd1},     32'd0);
    rst = 1'b0; sel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(1, 1'b0, 8'h03, 16'h0, 2'b11, rdv, erv, cyc);
    chk("rstmid_data", {16'b0, rdv}, 32'h1111);

    // Reset asserted on the completion cycle must also drop the write.
    sel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 16'hBEEF;
    @(posedge pclk); #1; penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk("rstcmp_pready", {31'b0, rdy[1]}, 32'd1);
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0; sel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(1, 1'b0, 8'h03, 16'h0, 2'b11, rdv, erv, cyc);
    chk("rstcmp_data", {16'b0, rdv}, 32'h1111);

    // Back-to-back with wait states.
    xfer(1, 1'b1, 8'h20, 16'h5AA5, 2'b11, rdv, erv, cyc);
    xfer(1, 1'b0, 8'h20, 16'h0,    2'b11, rdv, erv, cyc);
    chk("b2b_wait_data", {16'b0, rdv}, 32'h5AA5);

    // DEPTH=200: out-of-range accesses error out and touch nothing.
    for (int i = 0; i < 200; i++) begin
      xfer(2, 1'b1, 8'(i), 16'h5A00 + 16'(i), 2'b11, rdv, erv, cyc);
    end
    xfer(2, 1'b0, 8'd199, 16'h0, 2'b11, rdv, erv, cyc);
    chk("d200_last_data", {16'b0, rdv}, 32'h5AC7);
    chk("d200_last_err",  {31'b0, erv}, 32'd0);
    xfer(2, 1'b1, 8'd200, 16'h1234, 2'b11, rdv, erv, cyc);
    chk("d200_wr_err", {31'b0, erv}, 32'd1);
    chk("d200_wr_lat", 32'(cyc), 32'd1);
    chk("d200_idle_err", {31'b0, serr[2]}, 32'd0);
    xfer(2, 1'b0, 8'd200, 16'h0, 2'b11, rdv, erv, cyc);
    chk("d200_rd_err",  {31'b0, erv}, 32'd1);
    chk("d200_rd_data", {16'b0, rdv}, 32'h0);
    xfer(2, 1'b0, 8'd255, 16'h0, 2'b11, rdv, erv, cyc);
    chk("d200_rd255_err", {31'b0, erv}, 32'd1);
    for (int i = 0; i < 200; i++) begin
      xfer(2, 1'b0, 8'(i), 16'h0, 2'b11, rdv, erv, cyc);
      chk("d200_keep_data", {16'b0, rdv}, 32'h5A00 + 32'(i));
      chk("d200_keep_err",  {31'b0, erv}, 32'd0);
    end

`ifdef APB_PSTRB_EN
    // Byte-lane strobes.
    xfer(0, 1'b1, 8'h05, 16'hFFFF, 2'b11, rdv, erv, cyc);
    xfer(0, 1'b1, 8'h05, 16'h1200, 2'b10, rdv, erv, cyc);
    xfer(0, 1'b0, 8'h05, 16'h0,    2'b00, rdv, erv, cyc);
    chk("strb_hi_data", {16'b0, rdv}, 32'h12FF);
    xfer(0, 1'b1, 8'h05, 16'h0000, 2'b00, rdv, erv, cyc);
    chk("strb_none_err", {31'b0, erv}, 32'd0);
    xfer(0, 1'b0, 8'h05, 16'h0, 2'b11, rdv, erv, cyc);
    chk("strb_none_data", {16'b0, rdv}, 32'h12FF);
    xfer(0, 1'b1, 8'h05, 16'h3456, 2'b01, rdv, erv, cyc);
    xfer(0, 1'b0, 8'h05, 16'h0, 2'b11, rdv, erv, cyc);
    chk("strb_lo_data", {16'b0, rdv}, 32'h1256);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
